// File: rtl/vga_pkg.sv
// Shared constants, configuration address map and collision pair numbering
// for the VGA layer arbiter and anything that talks to it.
package vga_pkg;

  localparam int COLOR_W     = 8;
  localparam int RGB_W       = 3 * COLOR_W;
  localparam int FILL_EN_BIT = 24;

  typedef enum logic [1:0] {
    CFG_ENABLE = 2'd0,
    CFG_PRIO   = 2'd1,
    CFG_FILL   = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_addr_e;

  // Pairs (i<j) are numbered (0,1),(0,2)..(0,n-1),(1,2).. starting at bit 0.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/vga_collision_tracker.sv
// Per-frame sticky collision accumulator: flags every pair of masked layers
// that overlap on a visible pixel and publishes the set at each frame start.
module vga_collision_tracker
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int PAIRS      = NUM_LAYERS * (NUM_LAYERS - 1) / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_frame_start,
  input  logic                  i_active,
  input  logic [NUM_LAYERS-1:0] i_masked_hit,
  output logic [PAIRS-1:0]      o_collision,
  output logic                  o_collision_valid
);

  logic [PAIRS-1:0] pair_hit;
  logic [PAIRS-1:0] acc_d, acc_q;
  logic [PAIRS-1:0] coll_d, coll_q;
  logic             valid_d, valid_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pair_hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      for (int j = i + 1; j < NUM_LAYERS; j++) begin
        pair_hit[pair_index(i, j, NUM_LAYERS)] = i_active & i_masked_hit[i] & i_masked_hit[j];
      end
    end
  end

  // A hit on the frame-start cycle belongs to the frame that is just beginning.
  always_comb begin
    acc_d   = i_frame_start ? pair_hit : (acc_q | pair_hit);
    coll_d  = i_frame_start ? acc_q : coll_q;
    valid_d = i_frame_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      coll_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
      acc_q   <= acc_d;
      coll_q  <= coll_d;
      valid_q <= valid_d;
    end
  end

  assign o_collision       = coll_q;
  assign o_collision_valid = valid_q;

endmodule

// File: rtl/vga_layer_arbiter.sv
// Per-pixel ownership of the VGA output between the background and the sprite
// layers, with frame-synchronous configuration and collision reporting.
module vga_layer_arbiter #(
  parameter  int NUM_LAYERS = 4,
  parameter  int COLOR_W    = vga_pkg::COLOR_W,
  localparam int RGB_W      = 3 * COLOR_W,
  localparam int PAIRS      = NUM_LAYERS * (NUM_LAYERS - 1) / 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_frame_start,
  input  logic                        i_active,
  input  logic [RGB_W-1:0]            i_bg_rgb,
  input  logic [NUM_LAYERS-1:0]       i_layer_hit,
  input  logic [NUM_LAYERS*RGB_W-1:0] i_layer_rgb,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [1:0]                  cfg_addr,
  input  logic [31:0]                 cfg_data,
  output logic [RGB_W-1:0]            o_rgb,
  output logic                        o_active,
  output logic [PAIRS-1:0]            o_collision,
  output logic                        o_collision_valid
);

  localparam int IDX_W = $clog2(NUM_LAYERS);

  logic                  ready_q;
  logic                  unused_cfg_data;

  logic [NUM_LAYERS-1:0] shadow_en_d, shadow_en_q;
  logic                  shadow_rev_d, shadow_rev_q;
  logic                  shadow_fill_en_d, shadow_fill_en_q;
  logic [RGB_W-1:0]      shadow_fill_rgb_d, shadow_fill_rgb_q;

  logic [NUM_LAYERS-1:0] act_en_d, act_en_q;
  logic                  act_rev_d, act_rev_q;
  logic                  act_fill_en_d, act_fill_en_q;
  logic [RGB_W-1:0]      act_fill_rgb_d, act_fill_rgb_q;

  logic [NUM_LAYERS-1:0] s1_masked_d, s1_masked_q;
  logic [IDX_W-1:0]      s1_win_idx_d, s1_win_idx_q;
  logic [RGB_W-1:0]      s1_win_rgb_d, s1_win_rgb_q;
  logic [RGB_W-1:0]      s1_bg_d, s1_bg_q;
  logic                  s1_active_d, s1_active_q;
  logic                  s1_fill_en_d, s1_fill_en_q;
  logic [RGB_W-1:0]      s1_fill_rgb_d, s1_fill_rgb_q;

  logic [RGB_W-1:0]      rgb_d, rgb_q;
  logic                  active_d, active_q;

  assign cfg_ready       = ready_q & ~i_frame_start;
  assign unused_cfg_data = ^cfg_data[31:vga_pkg::FILL_EN_BIT+1];

  // Host writes only ever touch the shadow copy.
  always_comb begin
    shadow_en_d       = shadow_en_q;
    shadow_rev_d      = shadow_rev_q;
    shadow_fill_en_d  = shadow_fill_en_q;
    shadow_fill_rgb_d = shadow_fill_rgb_q;
    if (cfg_valid && cfg_ready) begin
      case (vga_pkg::cfg_addr_e'(cfg_addr))
        vga_pkg::CFG_ENABLE: shadow_en_d = cfg_data[NUM_LAYERS-1:0];
        vga_pkg::CFG_PRIO:   shadow_rev_d = cfg_data[0];
        vga_pkg::CFG_FILL: begin
          shadow_fill_rgb_d = cfg_data[RGB_W-1:0];
          shadow_fill_en_d  = cfg_data[vga_pkg::FILL_EN_BIT];
        end
        default: ;
      endcase
    end
  end

  // The *_d view is also what the current pixel uses, so the commit cycle
  // already sees the new configuration.
  always_comb begin
    act_en_d       = i_frame_start ? shadow_en_q       : act_en_q;
    act_rev_d      = i_frame_start ? shadow_rev_q      : act_rev_q;
    act_fill_en_d  = i_frame_start ? shadow_fill_en_q  : act_fill_en_q;
    act_fill_rgb_d = i_frame_start ? shadow_fill_rgb_q : act_fill_rgb_q;
  end

  always_comb begin
    s1_masked_d   = i_layer_hit & act_en_d;
    s1_bg_d       = i_bg_rgb;
    s1_active_d   = i_active;
    s1_fill_en_d  = act_fill_en_d;
    s1_fill_rgb_d = act_fill_rgb_d;
    s1_win_idx_d  = '0;
    s1_win_rgb_d  = '0;
    // Scan towards the preferred end; the last masked hit seen wins.
    if (act_rev_d) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (s1_masked_d[k]) begin
          s1_win_idx_d = IDX_W'(k);
          s1_win_rgb_d = i_layer_rgb[k*RGB_W +: RGB_W];
        end
      end
    end else begin
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
        if (s1_masked_d[k]) begin
          s1_win_idx_d = IDX_W'(k);
          s1_win_rgb_d = i_layer_rgb[k*RGB_W +: RGB_W];
        end
      end
    end
  end

  // With no masked hit the index stays 0 and that layer's bit is clear.
  always_comb begin
    rgb_d    = '0;
    active_d = s1_active_q;
    if (s1_active_q) begin
      if (s1_fill_en_q)                   rgb_d = s1_fill_rgb_q;
      else if (s1_masked_q[s1_win_idx_q]) rgb_d = s1_win_rgb_q;
      else                                rgb_d = s1_bg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q           <= 1'b0;
      shadow_en_q       <= '1;
      shadow_rev_q      <= 1'b0;
      shadow_fill_en_q  <= 1'b0;
      shadow_fill_rgb_q <= '0;
      act_en_q          <= '1;
      act_rev_q         <= 1'b0;
      act_fill_en_q     <= 1'b0;
      act_fill_rgb_q    <= '0;
    end else begin
      ready_q           <= 1'b1;
      shadow_en_q       <= shadow_en_d;
      shadow_rev_q      <= shadow_rev_d;
      shadow_fill_en_q  <= shadow_fill_en_d;
      shadow_fill_rgb_q <= shadow_fill_rgb_d;
      act_en_q          <= act_en_d;
      act_rev_q         <= act_rev_d;
      act_fill_en_q     <= act_fill_en_d;
      act_fill_rgb_q    <= act_fill_rgb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_masked_q   <= '0;
      s1_win_idx_q  <= '0;
      s1_win_rgb_q  <= '0;
      s1_bg_q       <= '0;
      s1_active_q   <= 1'b0;
      s1_fill_en_q  <= 1'b0;
      s1_fill_rgb_q <= '0;
      rgb_q         <= '0;
      active_q      <= 1'b0;
    end else begin
      s1_masked_q   <= s1_masked_d;
      s1_win_idx_q  <= s1_win_idx_d;
      s1_win_rgb_q  <= s1_win_rgb_d;
      s1_bg_q       <= s1_bg_d;
      s1_active_q   <= s1_active_d;
      s1_fill_en_q  <= s1_fill_en_d;
      s1_fill_rgb_q <= s1_fill_rgb_d;
      rgb_q         <= rgb_d;
      active_q      <= active_d;
    end
  end

  assign o_rgb    = rgb_q;
  assign o_active = active_q;

  vga_collision_tracker #(
    .NUM_LAYERS (NUM_LAYERS),
    .PAIRS      (PAIRS)
  ) u_collision (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_frame_start     (i_frame_start),
    .i_active          (i_active),
    .i_masked_hit      (s1_masked_d),
    .o_collision       (o_collision),
    .o_collision_valid (o_collision_valid)
  );

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Scoreboard bench for vga_layer_arbiter: directed pixels push hand-computed
// expectations, a negedge monitor pops them as the DUT presents output.
module tb_vga_layer_arbiter;
  import vga_pkg::*;

  localparam int          N     = 4;
  localparam int          NP    = N * (N - 1) / 2;
  localparam logic [23:0] BG    = 24'h0387D0;
  localparam logic [23:0] L0    = 24'hA0A0A0;
  localparam logic [23:0] L1    = 24'h111111;
  localparam logic [23:0] L2    = 24'h222222;
  localparam logic [23:0] L3    = 24'h333333;
  localparam logic [23:0] FILLC = 24'h123456;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_frame_start, i_active;
  logic [23:0]       i_bg_rgb;
  logic [N-1:0]      i_layer_hit;
  logic [N*24-1:0]   i_layer_rgb;
  logic              cfg_valid, cfg_ready;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_data;
  logic [23:0]       o_rgb;
  logic              o_active;
  logic [NP-1:0]     o_collision;
  logic              o_collision_valid;

  vga_layer_arbiter #(.NUM_LAYERS(N), .COLOR_W(COLOR_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_frame_start     (i_frame_start),
    .i_active          (i_active),
    .i_bg_rgb          (i_bg_rgb),
    .i_layer_hit       (i_layer_hit),
    .i_layer_rgb       (i_layer_rgb),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .o_rgb             (o_rgb),
    .o_active          (o_active),
    .o_collision       (o_collision),
    .o_collision_valid (o_collision_valid)
  );

  always #5 clk = ~clk;

  typedef struct {logic [23:0] rgb; int cyc;} pix_exp_t;
  typedef struct {logic [NP-1:0] v; int cyc;} coll_exp_t;

  pix_exp_t  pix_q[$];
  coll_exp_t coll_q[$];
  int        checks   = 0;
  int        failures = 0;
  int        cyc      = 0;
  logic      mon_en   = 1'b0;
  logic      cv       = 1'b0;
  logic [1:0]  ca     = '0;
  logic [31:0] cd     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    pix_exp_t  pe;
    coll_exp_t ce;
    if (mon_en) begin
      if (o_active) begin
        if (pix_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL pix_unexpected got=%0h want=no_output", o_rgb);
        end else begin
          pe = pix_q.pop_front();
          check("pix_rgb", o_rgb, pe.rgb);
          check("pix_cycle", cyc, pe.cyc);
        end
      end else begin
        check("blank_rgb", o_rgb, 32'd0);
      end
      if (o_collision_valid) begin
        if (coll_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL coll_unexpected got=%0h want=no_pulse", o_collision);
        end else begin
          ce = coll_q.pop_front();
          check("collision", o_collision, ce.v);
          check("coll_cycle", cyc, ce.cyc);
        end
      end
    end
  end

  task automatic cfg_req(input logic [1:0] addr, input logic [31:0] data);
    cv = 1'b1; ca = addr; cd = data;
  endtask

  // One pixel: drive after the edge, queue expectations, track the handshake.
  task automatic step(input logic fs, input logic act, input logic [N-1:0] hit,
                      input logic [23:0] exp_rgb, input logic [NP-1:0] exp_coll);
    @(posedge clk); #1;
    i_frame_start = fs; i_active = act; i_layer_hit = hit;
    cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
    if (act) pix_q.push_back('{exp_rgb, cyc + 2});
    if (fs)  coll_q.push_back('{exp_coll, cyc + 1});
    #1;
    if (cv) begin
      check("cfg_ready", cfg_ready, !fs);
      if (cfg_ready) cv = 1'b0;
    end
  endtask

  initial begin
    logic [NP-1:0] p13;
    p13 = NP'(1) << pair_index(1, 3, N);
    rst_n = 1'b0;
    i_frame_start = 0; i_active = 0; i_bg_rgb = BG; i_layer_hit = '0;
    i_layer_rgb = {L3, L2, L1, L0};
    cfg_valid = 0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", o_rgb, 32'd0);
    check("rst_active", o_active, 32'd0);
    check("rst_coll", o_collision, 32'd0);
    check("rst_coll_valid", o_collision_valid, 32'd0);
    check("rst_cfg_ready", cfg_ready, 32'd0);
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

    // Background passes through with two cycles of latency.
    step(0, 1, 4'b0000, BG, '0);
    step(0, 0, 4'b0000, '0, '0);
    step(0, 0, 4'b0000, '0, '0);

    // Lowest index wins; reverse takes effect on the commit pixel.
    step(0, 1, 4'b1010, L1, '0);
    cfg_req(CFG_PRIO, 32'd1);
    step(0, 1, 4'b1010, L1, '0);
    step(0, 1, 4'b1010, L1, '0);
    step(1, 1, 4'b1010, L3, p13);
    step(0, 1, 4'b1010, L3, '0);

    // Mid-frame enable write hides layer 1 only from the next frame.
    cfg_req(CFG_ENABLE, 32'h0000_000D);
    step(0, 1, 4'b0010, L1, '0);
    step(0, 1, 4'b0010, L1, '0);
    step(1, 1, 4'b0010, BG, p13);
    step(0, 1, 4'b0010, BG, '0);

    // Visible (0,2) overlap counts, blanked (2,3) overlap does not.
    step(0, 1, 4'b0101, L2, '0);
    step(0, 0, 4'b1100, '0, '0);
    step(1, 1, 4'b0000, BG, 6'b000010);
    step(0, 1, 4'b0000, BG, '0);
    step(1, 0, 4'b0000, '0, 6'b000000);

    // Write held across a frame start stalls, then lands for the next frame.
    cfg_req(CFG_PRIO, 32'd0);
    step(1, 1, 4'b0101, L2, 6'b000000);
    step(0, 1, 4'b0101, L2, '0);
    step(0, 1, 4'b0101, L2, '0);
    step(1, 1, 4'b0101, L0, 6'b000010);
    step(0, 1, 4'b0101, L0, '0);

    // Fill overrides everything, but blanking still forces black.
    cfg_req(CFG_FILL, 32'h0112_3456);
    step(0, 1, 4'b0000, BG, '0);
    step(1, 1, 4'b0101, FILLC, 6'b000010);
    step(0, 0, 4'b0101, '0, '0);
    step(0, 1, 4'b0000, FILLC, '0);
    step(0, 1, 4'b1010, FILLC, '0);
    step(0, 1, 4'b1010, FILLC, '0);
    step(0, 1, 4'b1010, FILLC, '0);

    // Asynchronous reset in the middle of a line.
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_rgb", o_rgb, 32'd0);
    check("midrst_active", o_active, 32'd0);
    check("midrst_coll", o_collision, 32'd0);
    check("midrst_cfg_ready", cfg_ready, 32'd0);
    i_frame_start = 0; i_active = 0; i_layer_hit = '0; cfg_valid = 0; cv = 0;
    pix_q.delete();
    coll_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1; mon_en = 1'b1;

    // Configuration is back to defaults: all enabled, lowest wins, no fill.
    step(0, 0, 4'b0000, '0, '0);
    step(0, 1, 4'b1010, L1, '0);
    step(0, 1, 4'b0000, BG, '0);
    step(1, 0, 4'b0000, '0, p13);
    for (int i = 0; i < 4; i++) step(0, 0, 4'b0000, '0, '0);
    @(negedge clk); #1;
    check("pix_queue_drained", pix_q.size(), 32'd0);
    check("coll_queue_drained", coll_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_layer_arbiter.md
Name: vga_layer_arbiter

Overview:
- Shares the single 24-bit VGA pixel output between the background generator and NUM_LAYERS sprite/object layers.
- Resolves per-pixel ownership by priority and applies per-layer enables, committing them only at frame boundaries so there is no mid-frame tearing.
- Records pairwise layer collisions per frame for the game logic.
- Sits between the timing/background generator and the DAC/output pins.

Parameters:
- NUM_LAYERS, 4, number of sprite layers (legal range 2..8).
- COLOR_W, 8, bits per colour channel; RGB_W = 3*COLOR_W.
- PAIRS, NUM_LAYERS*(NUM_LAYERS-1)/2, derived; width of the collision vector.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- rst_n  in  1  asynchronous, active-low reset.
- i_frame_start  in  1  one-cycle pulse from the timing generator at frame start (in blanking).
- i_active  in  1  current pixel is in the visible area.
- i_bg_rgb  in  RGB_W  background colour, {red, green, blue}.
- i_layer_hit  in  NUM_LAYERS  layer k covers the current pixel.
- i_layer_rgb  in  NUM_LAYERS*RGB_W  colour of layer k in slice k.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_addr  in  2  register select.
- cfg_data  in  32  write data.
- o_rgb  out  RGB_W  arbitrated pixel colour.
- o_active  out  1  i_active delayed to align with o_rgb.
- o_collision  out  PAIRS  collision flags of the last completed frame.
- o_collision_valid  out  1  one-cycle pulse when o_collision updates.

Behaviour:
- Reset: o_rgb=0, o_active=0, o_collision=0, o_collision_valid=0, cfg_ready=0 while rst_n is low.
- Reset values of the shadow and active configuration registers:
  - enable mask = all ones
  - reverse = 0
  - fill_en = 0, fill_rgb = 0
- Config map: addr0 = enable mask [NUM_LAYERS-1:0]; addr1 = reverse priority, bit0; addr2 = fill_rgb [RGB_W-1:0] plus fill_en at bit 24; addr3 is reserved (accepted, no effect).
- Writes land in the shadow registers only.
- cfg_ready = ~i_frame_start when out of reset. A write held during the commit cycle stalls one cycle; the requester keeps cfg_valid and cfg_data stable.
- Commit: on a cycle with i_frame_start high, the shadow registers are copied to the active registers. That cycle's pixel already uses the new active values.
- Pipeline, 2 cycles from inputs to o_rgb/o_active:
  - Stage 1 registers the masked hits (i_layer_hit & enable), the winner index, the winner colour, the background colour and i_active.
  - Stage 2 produces the output.
- Priority: with reverse=0 the lowest index wins; with reverse=1 the highest index wins. With no masked hit, the background wins.
- fill_en=1 overrides every source with fill_rgb.
- o_rgb = 0 whenever the delayed active flag is 0.
- Collisions: for each pair (i<j), the flag sets when i_active && masked hit i && masked hit j. Pair index ordering: (0,1), (0,2), …, (0,N-1), (1,2), … ascending. Flags are sticky within a frame.
- Frame rollover:
  - On i_frame_start, o_collision <= accumulator and the accumulator clears.
  - A collision in that same cycle counts toward the new frame.
  - o_collision_valid pulses the cycle after i_frame_start.
- An i_frame_start during active video still commits and rolls over. There is no special-case logic.
- Reset mid-frame clears the pipeline immediately (asynchronously). The first output after reset release is valid only after 2 cycles.
- All widths are unsigned; there is no arithmetic beyond index compares.

Decomposition:
- vga_pkg:
  - COLOR_W and RGB_W
  - cfg address constants CFG_ENABLE=0, CFG_PRIO=1, CFG_FILL=2
  - a pair_index(i,j) function shared by RTL and bench
- Sub-module vga_collision_tracker: pair detection, sticky accumulator, frame rollover and valid pulse. The priority mux stays in the top level.

Test Plan:
- Reset, then i_active=1, no hits, i_bg_rgb=24'h0387D0 -> o_rgb=24'h0387D0 exactly 2 cycles later; o_active aligned with it.
- Layers 1 and 3 hit with colours 24'h111111/24'h333333, reverse=0 -> 24'h111111. Write addr1=1, pulse i_frame_start -> 24'h333333 from the commit cycle's pixel onward, never before.
- Write addr0=4'b1101 mid-frame -> layer 1 still visible until the next i_frame_start, hidden afterwards.
- Layers 0 and 2 overlap for one active pixel; 2 and 3 overlap only while i_active=0 -> at the next frame start only pair (0,2) is set: o_collision=6'b000010 with the ordering (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) LSB-first. The following frame reports 0 if there is no overlap.
- cfg_valid held across an i_frame_start cycle -> no acceptance that cycle, accepted the next cycle, applied at the following frame start.
- Assert rst_n=0 mid-line with a winning layer -> o_rgb=0, o_collision=0 immediately; shadow and active registers return to their reset values.
